// File: rtl/load_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : load_ext_pipe
// Brief    : Registered RISC-V load extractor/extender with valid/ready
//            handshake, misalignment/illegal flagging and saturating fault count.
// Revision : 1.0
// ============================================================================
module load_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_word,
    input  logic [$clog2(XLEN/8)-1:0]  in_off,
    input  logic [2:0]                 in_funct3,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_err,
    output logic [CNT_W-1:0]           fault_cnt
);

    localparam int OFF_W = $clog2(XLEN/8);
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    logic              r_valid;
    logic [XLEN-1:0]   r_data;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;
    logic [CNT_W-1:0]  r_fault_cnt;

    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_ext;
    logic              w_legal;
    logic              w_misal;
    logic              w_err;
    logic              w_in_fire;
    logic              w_out_fire;

    // Little-endian lane select: shift the addressed byte down to bit 0.
    assign w_shifted = in_word >> {in_off, 3'b000};

    always_comb begin
        w_ext   = '0;
        w_legal = 1'b1;
        w_misal = 1'b0;
        case (in_funct3)
            F3_LB:  w_ext = XLEN'($signed(w_shifted[7:0]));
            F3_LBU: w_ext = XLEN'(w_shifted[7:0]);
            F3_LH: begin
                w_ext   = XLEN'($signed(w_shifted[15:0]));
                w_misal = in_off[0];
            end
            F3_LHU: begin
                w_ext   = XLEN'(w_shifted[15:0]);
                w_misal = in_off[0];
            end
            F3_LW: begin
                w_ext   = XLEN'($signed(w_shifted[31:0]));
                w_misal = (in_off[1:0] != 2'b00);
            end
            F3_LWU: begin
                w_ext   = XLEN'(w_shifted[31:0]);
                w_misal = (in_off[1:0] != 2'b00);
                w_legal = (XLEN == 64);
            end
            F3_LD: begin
                w_ext   = in_word;
                w_misal = (in_off != {OFF_W{1'b0}});
                w_legal = (XLEN == 64);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_err      = !w_legal || w_misal;
    assign in_ready   = !r_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_tag       <= '0;
            r_err       <= 1'b0;
            r_fault_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_valid <= 1'b1;
                r_data  <= w_err ? '0 : w_ext;
                r_tag   <= in_tag;
                r_err   <= w_err;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end
            if (w_in_fire && w_err && (r_fault_cnt != {CNT_W{1'b1}})) begin
                r_fault_cnt <= r_fault_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_tag   = r_tag;
    assign out_err   = r_err;
    assign fault_cnt = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_load_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_ext_pipe
// Brief    : Scoreboard bench for load_ext_pipe (XLEN=32, XLEN=64, CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_load_ext_pipe;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        iv   = '0;
    logic [2:0]        ordy = 3'b111;
    logic [2:0][63:0]  iw   = '0;
    logic [2:0][2:0]   ioff = '0;
    logic [2:0][2:0]   if3  = '0;
    logic [2:0][4:0]   itg  = '0;

    wire [2:0]  ir, ov, oerr;
    wire [4:0]  otag0, otag1, otag2;
    wire [31:0] od0, od2;
    wire [63:0] od1;
    wire [7:0]  cnt0, cnt1;
    wire [1:0]  cnt2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    logic [2:0]       pstall = '0;
    logic [2:0][63:0] pd;
    logic [2:0][4:0]  pt;
    logic [2:0]       pe;

    load_ext_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) u_x32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_word(iw[0][31:0]), .in_off(ioff[0][1:0]), .in_funct3(if3[0]),
        .in_tag(itg[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od0), .out_tag(otag0), .out_err(oerr[0]), .fault_cnt(cnt0)
    );

    load_ext_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) u_x64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_word(iw[1]), .in_off(ioff[1]), .in_funct3(if3[1]),
        .in_tag(itg[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_tag(otag1), .out_err(oerr[1]), .fault_cnt(cnt1)
    );

    load_ext_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_word(iw[2][31:0]), .in_off(ioff[2][1:0]), .in_funct3(if3[2]),
        .in_tag(itg[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od2), .out_tag(otag2), .out_err(oerr[2]), .fault_cnt(cnt2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic r, input logic [63:0] d,
                       input logic [4:0] t, input logic e, input logic [7:0] c);
        exp_t x;
        logic ok;
        if (pstall[i] && v) begin
            chk($sformatf("hold_data%0d", i), d, pd[i]);
            chk($sformatf("hold_tag%0d", i), 64'(t), 64'(pt[i]));
            chk($sformatf("hold_err%0d", i), 64'(e), 64'(pe[i]));
        end
        if (v && r) begin
            ok = 1'b0;
            case (i)
                0: if (q0.size() > 0) begin x = q0.pop_front(); ok = 1'b1; end
                1: if (q1.size() > 0) begin x = q1.pop_front(); ok = 1'b1; end
                default: if (q2.size() > 0) begin x = q2.pop_front(); ok = 1'b1; end
            endcase
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat%0d: got tag %0d expected no beat", i, t);
            end else begin
                chk($sformatf("data%0d_tag%0d", i, x.tag), d, x.data);
                chk($sformatf("tag%0d", i), 64'(t), 64'(x.tag));
                chk($sformatf("err%0d_tag%0d", i, x.tag), 64'(e), 64'(x.err));
                chk($sformatf("cnt%0d_tag%0d", i, x.tag), 64'(c), 64'(x.cnt));
            end
        end
        pstall[i] = v && !r;
        pd[i] = d;
        pt[i] = t;
        pe[i] = e;
    endtask

    // Monitor: decoupled from stimulus, consumes a scoreboard entry per output fire.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, ov[0], ordy[0], {32'b0, od0}, otag0, oerr[0], cnt0);
            mon(1, ov[1], ordy[1], od1, otag1, oerr[1], cnt1);
            mon(2, ov[2], ordy[2], {32'b0, od2}, otag2, oerr[2], {6'b0, cnt2});
        end else begin
            pstall = '0;
        end
    end

    task automatic send(input int i, input logic [2:0] f3, input logic [2:0] o,
                        input logic [63:0] w, input logic [4:0] t,
                        input logic [63:0] ed, input logic ee, input logic [7:0] ec);
        exp_t x;
        logic rdy;
        int n;
        x.data = ed; x.tag = t; x.err = ee; x.cnt = ec;
        case (i)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
        if3[i] = f3; ioff[i] = o; iw[i] = w; itg[i] = t; iv[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = ir[i];
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d: got in_ready 0 expected 1", i);
        end
        iv[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(ov), 64'd0);
        chk("rst_ready", 64'(ir), 64'h7);
        chk("rst_err", 64'(oerr), 64'd0);
        chk("rst_data0", 64'(od0), 64'd0);
        chk("rst_data1", od1, 64'd0);
        chk("rst_tag0", 64'(otag0), 64'd0);
        chk("rst_cnt0", 64'(cnt0), 64'd0);
        chk("rst_cnt2", 64'(cnt2), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // XLEN=32 extraction and extension
        send(0, 3'b000, 3'd1, 64'h80FF_7F01, 5'd1, 64'h0000_007F, 1'b0, 8'd0);
        send(0, 3'b000, 3'd3, 64'h80FF_7F01, 5'd2, 64'hFFFF_FF80, 1'b0, 8'd0);
        send(0, 3'b001, 3'd2, 64'h9234_5678, 5'd5, 64'hFFFF_9234, 1'b0, 8'd0);
        send(0, 3'b101, 3'd2, 64'h9234_5678, 5'd6, 64'h0000_9234, 1'b0, 8'd0);
        send(0, 3'b001, 3'd1, 64'h9234_5678, 5'd7, 64'd0, 1'b1, 8'd1);
        send(0, 3'b010, 3'd0, 64'h8000_0001, 5'd8, 64'h8000_0001, 1'b0, 8'd1);
        send(0, 3'b011, 3'd0, 64'h8000_0001, 5'd9, 64'd0, 1'b1, 8'd2);
        send(0, 3'b100, 3'd0, 64'h0000_00A5, 5'd10, 64'h0000_00A5, 1'b0, 8'd2);

        // XLEN=64 instance
        send(1, 3'b010, 3'd4, 64'h8000_0001_0000_0000, 5'd1, 64'hFFFF_FFFF_8000_0001, 1'b0, 8'd0);
        send(1, 3'b110, 3'd4, 64'h8000_0001_0000_0000, 5'd2, 64'h0000_0000_8000_0001, 1'b0, 8'd0);
        send(1, 3'b011, 3'd0, 64'h8000_0001_0000_0000, 5'd3, 64'h8000_0001_0000_0000, 1'b0, 8'd0);
        send(1, 3'b000, 3'd7, 64'h8000_0001_0000_0000, 5'd4, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 8'd0);
        send(1, 3'b011, 3'd4, 64'h8000_0001_0000_0000, 5'd5, 64'd0, 1'b1, 8'd1);
        send(1, 3'b010, 3'd2, 64'h8000_0001_0000_0000, 5'd6, 64'd0, 1'b1, 8'd2);

        // Saturating counter, CNT_W=2
        send(2, 3'b111, 3'd0, 64'h1234_5678, 5'd1, 64'd0, 1'b1, 8'd1);
        send(2, 3'b111, 3'd0, 64'h1234_5678, 5'd2, 64'd0, 1'b1, 8'd2);
        send(2, 3'b111, 3'd0, 64'h1234_5678, 5'd3, 64'd0, 1'b1, 8'd3);
        send(2, 3'b111, 3'd0, 64'h1234_5678, 5'd4, 64'd0, 1'b1, 8'd3);
        send(2, 3'b111, 3'd0, 64'h1234_5678, 5'd5, 64'd0, 1'b1, 8'd3);
        drain();

        // Backpressure: tag 3 held, tag 4 waits
        ordy[0] = 1'b0;
        send(0, 3'b100, 3'd2, 64'h00C3_0000, 5'd3, 64'h0000_00C3, 1'b0, 8'd2);
        q0.push_back('{64'h0000_BEEF, 5'd4, 1'b0, 8'd2});
        if3[0] = 3'b101; ioff[0] = 3'd0; iw[0] = 64'h0000_BEEF; itg[0] = 5'd4; iv[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 64'(ir[0]), 64'd0);
            chk("bp_valid", 64'(ov[0]), 64'd1);
            chk("bp_tag", 64'(otag0), 64'd3);
            chk("bp_data", 64'(od0), 64'h0000_00C3);
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("bp_tag4_valid", 64'(ov[0]), 64'd1);
        chk("bp_tag4_tag", 64'(otag0), 64'd4);
        drain();

        // Reset mid-operation while stalled with a pending input
        ordy[0] = 1'b0;
        send(0, 3'b000, 3'd0, 64'h0000_0011, 5'd11, 64'h0000_0011, 1'b0, 8'd2);
        if3[0] = 3'b111; ioff[0] = 3'd0; iw[0] = 64'h0; itg[0] = 5'd12; iv[0] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q0.delete();
        chk("mid_rst_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_cnt", 64'(cnt0), 64'd0);
        chk("mid_rst_tag", 64'(otag0), 64'd0);
        iv[0] = 1'b0;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(ov[0]), 64'd0);
        chk("post_rst_cnt", 64'(cnt0), 64'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
